// File: rtl/mux_sel_scanner.sv
// Round-robin select generator for a 4:1 mux.
// Skips unrequested channels, dwells DWELL cycles on each, flags wrap.
module mux_sel_scanner #(
    parameter int DWELL   = 4,
    parameter int DWELL_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    input  logic       hold,
    output logic       s0,
    output logic       s1,
    output logic       sel_valid,
    output logic       wrap
);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    localparam logic [DWELL_W-1:0] LAST = DWELL_W'(DWELL - 1);

    state_t             state;
    logic [1:0]         sel;
    logic [DWELL_W-1:0] cnt;
    logic [1:0]         first_idx;
    logic [1:0]         next_idx;
    logic [1:0]         probe;

    assign s0 = sel[0];
    assign s1 = sel[1];

    // Search the request mask: first_idx is inclusive of the current
    // select, next_idx is strictly after it (wrapping back onto itself
    // when it is the only requested channel).
    always_comb begin
        first_idx = sel;
        next_idx  = sel;
        probe     = sel;
        for (int k = 3; k >= 0; k--) begin
            probe = sel + 2'(k);
            if (req[probe]) first_idx = probe;
        end
        for (int k = 4; k >= 1; k--) begin
            probe = sel + 2'(k);
            if (req[probe]) next_idx = probe;
        end
    end

    // Scan state machine; every output is a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= 2'b00;
            sel_valid <= 1'b0;
            wrap      <= 1'b0;
            cnt       <= '0;
        end else begin
            wrap <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (en && (req != 4'b0000)) begin
                        sel       <= first_idx;
                        cnt       <= '0;
                        sel_valid <= 1'b1;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (!en || (req == 4'b0000)) begin
                        state     <= IDLE;
                        sel_valid <= 1'b0;
                        cnt       <= '0;
                    end else if (!req[sel] || (!hold && (cnt == LAST))) begin
                        // A dropped channel and an expiring dwell share one advance.
                        sel  <= next_idx;
                        cnt  <= '0;
                        wrap <= (next_idx <= sel);
                    end else if (!hold) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_sel_scanner.sv
// Self-checking bench for mux_sel_scanner: DWELL=4 and DWELL=1 instances
// driven in parallel and compared against a behavioural model.
module tb_mux_sel_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       hold = 1'b0;

    logic a_s0, a_s1, a_valid, a_wrap;
    logic b_s0, b_s1, b_valid, b_wrap;

    int checks = 0;
    int errors = 0;

    mux_sel_scanner #(.DWELL(4), .DWELL_W(4)) dut_a (
        .clk(clk), .rst(rst), .en(en), .req(req), .hold(hold),
        .s0(a_s0), .s1(a_s1), .sel_valid(a_valid), .wrap(a_wrap)
    );

    mux_sel_scanner #(.DWELL(1), .DWELL_W(4)) dut_b (
        .clk(clk), .rst(rst), .en(en), .req(req), .hold(hold),
        .s0(b_s0), .s1(b_s1), .sel_valid(b_valid), .wrap(b_wrap)
    );

    always #5 clk = ~clk;

    // Behavioural model: index 0 is the DWELL=4 unit, index 1 the DWELL=1 unit.
    int dwell [2] = '{4, 1};
    bit m_act [2];
    int m_ch [2];
    int m_spent [2];
    bit m_wrap [2];

    function automatic int find_req(int start, logic [3:0] r, int k0);
        for (int k = k0; k < k0 + 4; k++)
            if (r[(start + k) % 4]) return (start + k) % 4;
        return start;
    endfunction

    task automatic model_step(int i);
        int old;
        m_wrap[i] = 1'b0;
        if (rst) begin
            m_act[i] = 0; m_ch[i] = 0; m_spent[i] = 0;
        end else if (!m_act[i]) begin
            if (en && req != 0) begin
                m_ch[i] = find_req(m_ch[i], req, 0);
                m_act[i] = 1; m_spent[i] = 0;
            end
        end else if (!en || req == 0) begin
            m_act[i] = 0; m_spent[i] = 0;
        end else if (!req[m_ch[i]] || (!hold && m_spent[i] == dwell[i] - 1)) begin
            old = m_ch[i];
            m_ch[i] = find_req(old, req, 1);
            m_wrap[i] = (m_ch[i] <= old);
            m_spent[i] = 0;
        end else if (!hold) begin
            m_spent[i]++;
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sel_a();
        return {30'd0, a_s1, a_s0};
    endfunction

    function automatic int sel_b();
        return {30'd0, b_s1, b_s0};
    endfunction

    // One clock: update model with the inputs seen at the edge, then compare.
    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        chk("model_sel_a", sel_a(), m_ch[0]);
        chk("model_valid_a", a_valid, m_act[0]);
        chk("model_wrap_a", a_wrap, m_wrap[0]);
        chk("model_sel_b", sel_b(), m_ch[1]);
        chk("model_valid_b", b_valid, m_act[1]);
        chk("model_wrap_b", b_wrap, m_wrap[1]);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; hold = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] req;
        logic       hold;
        int         sel;
        bit         valid;
        bit         wrap;
    } vec_t;

    vec_t tbl [19];
    int   cnt;

    initial begin
        // Full scan on the DWELL=4 unit: four cycles per channel, wrap on 3->0.
        tbl[0] = '{1'b1, 1'b0, 4'hF, 1'b0, 0, 1'b0, 1'b0};
        for (int n = 1; n < 19; n++)
            tbl[n] = '{1'b0, 1'b1, 4'hF, 1'b0, ((n - 1) / 4) % 4, 1'b1, n == 17};

        for (int n = 0; n < 19; n++) begin
            rst = tbl[n].rst; en = tbl[n].en;
            req = tbl[n].req; hold = tbl[n].hold;
            tick();
            chk($sformatf("tbl_sel[%0d]", n), sel_a(), tbl[n].sel);
            chk($sformatf("tbl_valid[%0d]", n), a_valid, tbl[n].valid);
            chk($sformatf("tbl_wrap[%0d]", n), a_wrap, tbl[n].wrap);
        end

        // Sparse mask: only channels 1 and 3 may ever appear.
        do_reset();
        en = 1'b1; req = 4'b1010;
        cnt = 0;
        for (int n = 0; n < 16; n++) begin
            tick();
            chk("sparse_a_odd", a_s0, 1'b1);
            chk("sparse_b_odd", b_s0, 1'b1);
            if (b_wrap) cnt++;
        end
        chk("sparse_b_wraps", cnt, 7);

        // Hold for 3 cycles on channel 2 stretches its dwell to 7.
        do_reset();
        en = 1'b1; req = 4'hF;
        for (int n = 0; n < 9; n++) tick();
        chk("hold_on_ch2", sel_a(), 2);
        cnt = 1;
        for (int n = 0; n < 7; n++) begin
            hold = (n < 3);
            tick();
            if (sel_a() == 2) cnt++;
        end
        hold = 1'b0;
        chk("hold_dwell", cnt, 7);
        chk("hold_next", sel_a(), 3);

        // Request drop on channel 1 at counter 1, without and with hold.
        for (int h = 0; h < 2; h++) begin
            do_reset();
            en = 1'b1; req = 4'hF;
            for (int n = 0; n < 6; n++) tick();
            chk("drop_pre", sel_a(), 1);
            req = 4'b1101; hold = h[0];
            tick();
            hold = 1'b0;
            chk($sformatf("drop_sel_h%0d", h), sel_a(), 2);
            for (int n = 0; n < 3; n++) tick();
            chk($sformatf("drop_restart_h%0d", h), sel_a(), 2);
            tick();
            chk($sformatf("drop_adv_h%0d", h), sel_a(), 3);
        end

        // Single channel on the DWELL=1 unit: stays on 2, wraps every cycle.
        do_reset();
        en = 1'b1; req = 4'b0100;
        tick();
        chk("single_first_sel", sel_b(), 2);
        chk("single_first_wrap", b_wrap, 1'b0);
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("single_sel", sel_b(), 2);
            chk("single_wrap", b_wrap, 1'b1);
        end

        // Disable mid-scan, then reset mid-dwell on channel 3.
        do_reset();
        en = 1'b1; req = 4'hF;
        for (int n = 0; n < 6; n++) tick();
        en = 1'b0;
        tick();
        chk("dis_valid", a_valid, 1'b0);
        chk("dis_sel_hold", sel_a(), 1);
        en = 1'b1;
        for (int n = 0; n < 10; n++) tick();
        chk("rst_pre_ch3", sel_a(), 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_sel", sel_a(), 0);
        chk("rst_valid", a_valid, 1'b0);
        chk("rst_wrap", a_wrap, 1'b0);

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst  = ($urandom_range(0, 49) == 0);
            en   = ($urandom_range(0, 7) != 0);
            req  = ($urandom_range(0, 9) == 0) ? 4'b0000 : 4'($urandom);
            if ($urandom_range(0, 3) != 0 && n > 0) req = req | 4'b0001;
            hold = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
